// File: rtl/bus_arb_mux_pkg.sv
// rtl/bus_arb_mux_pkg.sv - shared defaults and index-width helper for bus_arb_mux
package bus_arb_pkg;

   localparam int N_CH_DEF = 4;
   localparam int DW_DEF   = 8;

   // Width of a binary index able to name any bit of an n-bit one-hot vector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_arb_mux_rr_arbiter.sv
// rtl/bus_arb_mux_rr_arbiter.sv - rotating-priority arbiter: requests + pointer -> one-hot grant and winner index
module rr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N_CH = N_CH_DEF,
   parameter int IW   = idx_w(N_CH)
) (
   input  logic [N_CH-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [N_CH-1:0] gnt_o,
   output logic [IW-1:0]   idx_o
);

   logic [2*N_CH-1:0] req_dbl;
   logic [N_CH-1:0]   req_rot;
   logic              found;
   int                off;
   int                sum;

   // Rotate requests so ptr sits at bit 0, take the first set bit, then rotate the offset back.
   always_comb begin
      req_dbl = {req_i, req_i} >> ptr_i;
      req_rot = req_dbl[N_CH-1:0];
      found   = 1'b0;
      off     = 0;
      for (int k = 0; k < N_CH; k++) begin
         if (!found && req_rot[k]) begin
            found = 1'b1;
            off   = k;
         end
      end
      sum = int'(ptr_i) + off;
      if (sum >= N_CH) begin
         sum = sum - N_CH;
      end
      idx_o = IW'(sum);
   end

   // Decode the winner index into the one-hot grant; no request means no grant.
   always_comb begin
      gnt_o = '0;
      for (int i = 0; i < N_CH; i++) begin
         gnt_o[i] = found && (idx_o == IW'(i));
      end
   end

endmodule

// File: rtl/bus_arb_mux.sv
// rtl/bus_arb_mux.sv - N-channel arbitrated mux into a single registered output slot (round robin when BUS_ARB_MUX_RR_EN is defined, fixed priority otherwise)
module bus_arb_mux
   import bus_arb_pkg::*;
#(
   parameter int N_CH = N_CH_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          in_valid,
   input  logic [N_CH*DW-1:0]       in_data,
   output logic [N_CH-1:0]          in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_data,
   output logic [$clog2(N_CH)-1:0]  out_ch
);

   localparam int IW = idx_w(N_CH);

   logic [N_CH-1:0] gnt;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   arb_ptr;
   logic [DW-1:0]   sel_data;
   logic            slot_free;
   logic            xfer;

   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_data_q,  out_data_d;
   logic [IW-1:0]   out_ch_q,    out_ch_d;

`ifdef BUS_ARB_MUX_RR_EN
   logic [IW-1:0]   ptr_q, ptr_d;

   assign arb_ptr = ptr_q;

   // Next search start is the channel just above the last winner, wrapping to 0.
   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         ptr_d = (int'(win_idx) == N_CH - 1) ? '0 : win_idx + IW'(1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign arb_ptr = '0;
`endif

   rr_arbiter #(
      .N_CH (N_CH),
      .IW   (IW)
   ) u_arb (
      .req_i (in_valid),
      .ptr_i (arb_ptr),
      .gnt_o (gnt),
      .idx_o (win_idx)
   );

   // Slot accepts when empty or being drained this cycle; reset blocks every handshake.
   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = gnt & {N_CH{slot_free & rst_n}};
   assign xfer      = |in_ready;

   // AND-OR data mux gated by the one-hot grant.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         sel_data = sel_data | (in_data[i*DW +: DW] & {DW{gnt[i]}});
      end
   end

   // Output slot next state: load on transfer, clear on drain-only, otherwise hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_ch_d    = win_idx;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output slot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: doc/bus_arb_mux.md
BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
- REQ-001 Parameter N_CH, default 4: number of input channels; legal range 2..16.
- REQ-002 Parameter DW, default 8: data width per channel; legal range 1..64.
- REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
- REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
- REQ-005 Port in_valid, input, N_CH: per-channel request; bit i is channel i.
- REQ-006 Port in_data, input, N_CH*DW: channel i occupies bits [i*DW +: DW].
- REQ-007 Port in_ready, output, N_CH: per-channel accept; a transfer on channel i occurs when in_valid[i] and in_ready[i] are both 1.
- REQ-008 Port out_valid, output, 1: output register holds a word.
- REQ-009 Port out_ready, input, 1: downstream accept.
- REQ-010 Port out_data, output, DW: registered selected word.
- REQ-011 Port out_ch, output, $clog2(N_CH): source channel index of out_data.

Function
- REQ-012 Grant SHALL be a one-hot vector derived by decoding the arbiter winner index; at most one in_ready bit SHALL be 1 in any cycle.
- REQ-013 Data selection SHALL be an AND-OR mux gated by the one-hot grant; no high-impedance value SHALL be driven anywhere in the block.
- REQ-014 Output slot is free when out_valid is 0, or when out_valid and out_ready are both 1.
- REQ-015 in_ready[i] SHALL be 1 only when channel i wins arbitration, in_valid[i] is 1, and the slot is free.
- REQ-016 On a transfer, out_data and out_ch SHALL load at the next edge and out_valid SHALL be 1; latency is exactly 1 cycle.
- REQ-017 With out_valid 1 and out_ready 0, out_data, out_ch and out_valid SHALL hold unchanged.
- REQ-018 Simultaneous drain and fill SHALL keep out_valid at 1 with the new word; full throughput is 1 word per cycle.
- REQ-019 Drain with no new transfer SHALL clear out_valid at the next edge.
- REQ-020 Round-robin pointer ptr (width $clog2(N_CH)): the winner is the first requesting channel at or after ptr, searching upward modulo N_CH.
- REQ-021 After a transfer from channel k, ptr SHALL become (k+1) mod N_CH; wrap from N_CH-1 to 0 is required. With no transfer, ptr SHALL hold.
- REQ-022 in_valid with no grant SHALL not alter any state; a requester may drop in_valid without penalty.

Reset
- REQ-023 While rst_n is 0: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, and in_ready = 0.
- REQ-024 A reset asserted mid-transfer SHALL discard the held word; no transfer SHALL be reported in the reset cycle.
- REQ-025 The first grant after reset deassertion SHALL follow ptr = 0.

Configuration
- REQ-026 Macro BUS_ARB_MUX_RR_EN defined: arbitration follows REQ-020 and REQ-021.
- REQ-027 Macro BUS_ARB_MUX_RR_EN undefined: arbitration is fixed priority (lowest index wins), ptr is absent, and all other behaviour is unchanged.

Structure
- REQ-028 Shared package bus_arb_pkg SHALL hold the default N_CH and DW constants and the function that returns the onehot-to-index width.
- REQ-029 One sub-module rr_arbiter (in_valid, ptr -> one-hot grant, winner index) SHALL contain all priority logic; the mux and output register stay in bus_arb_mux.

Verification (N_CH=4, DW=8)
- REQ-030 Reset test: hold rst_n=0 with all in_valid=1 -> out_valid=0, in_ready=0000; release reset -> channel 0 granted first.
- REQ-031 Fairness test: in_valid=1111 with data 0xA0..0xA3 and out_ready=1 -> out_ch sequence 0,1,2,3,0, one word per cycle.
- REQ-032 Backpressure test: out_ready=0 for 3 cycles with out_data=0x55 -> out_data holds 0x55, in_ready=0000; release -> next word follows 1 cycle later.
- REQ-033 Wrap test: only channel 3 sends (0x33), then in_valid=1001 -> channel 0 is granted next (ptr=0), then channel 3.
- REQ-034 Mid-operation reset test: assert rst_n=0 while out_valid=1 with 0x77 -> out_valid clears immediately; no 0x77 handshake is observed.
- REQ-035 Fixed-priority test: build without BUS_ARB_MUX_RR_EN, in_valid=0110 continuously -> out_ch is always 1.
